// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: source encodings, the
// queued entry layout and the PC step that LS results always carry.
package wb_arbiter_pkg;

    // wb_src encoding
    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LS  = 1'b1;

    // LS results never redirect the PC, so they carry the sequential step.
    localparam int DEFAULT_PC_STEP = 4;

    // Default field widths of one queued writeback entry.
    localparam int WB_POS_W  = 4;
    localparam int WB_RD_W   = 5;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 32;

    // Queued entry, packed as {pos, rd, value, offset} (pos in the MSBs).
    typedef struct packed {
        logic [WB_POS_W-1:0]  pos;
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] value;
        logic [WB_ADDR_W-1:0] offset;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending writeback entries for one source.
// Push and pop are qualified by the caller; count is the live occupancy.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = WB_ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage write; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues ALU and LS results in per-source FIFOs and
// drains one entry per cycle onto the registered writeback broadcast bus.
//
// Handshake: a source transfers an entry on a cycle where valid && ready at
// the rising edge; ready depends only on registered occupancy (and rst), never
// on the same-cycle pop, so a full FIFO refuses even while it is draining.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int SB_SIZE_WIDTH = 4,
    parameter int REG_WIDTH     = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int Q_DEPTH       = 2,
    parameter int ALU_PRIORITY  = 0,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [SB_SIZE_WIDTH-1:0] alu_pos,
    input  logic [REG_WIDTH-1:0]     alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_value,
    input  logic [ADDR_WIDTH-1:0]    alu_offset,
    input  logic                     ls_valid,
    output logic                     ls_ready,
    input  logic [SB_SIZE_WIDTH-1:0] ls_pos,
    input  logic [REG_WIDTH-1:0]     ls_rd,
    input  logic [DATA_WIDTH-1:0]    ls_value,
    output logic                     wb_valid,
    output logic                     wb_src,
    output logic [SB_SIZE_WIDTH-1:0] wb_pos,
    output logic [REG_WIDTH-1:0]     wb_rd,
    output logic [DATA_WIDTH-1:0]    wb_value,
    output logic [ADDR_WIDTH-1:0]    wb_offset
);

    localparam int ENTRY_W  = SB_SIZE_WIDTH + REG_WIDTH + DATA_WIDTH + ADDR_WIDTH;
    localparam int CNT_W    = $clog2(Q_DEPTH) + 1;
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    Q_FULL     = CNT_W'(Q_DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // Field positions inside a packed {pos, rd, value, offset} entry.
    localparam int VAL_LSB = ADDR_WIDTH;
    localparam int RD_LSB  = VAL_LSB + DATA_WIDTH;
    localparam int POS_LSB = RD_LSB + REG_WIDTH;

    logic [CNT_W-1:0]   alu_count, ls_count;
    logic [ENTRY_W-1:0] alu_head, ls_head, sel_entry;
    logic               alu_push, ls_push, alu_pop, ls_pop;
    logic               alu_nonempty, ls_nonempty;
    logic               grant_valid, grant;
    logic               last_grant;
    logic [STARVE_W-1:0] starve_cnt;
    logic [REG_WIDTH-1:0] sel_rd;

    assign alu_ready = !rst && (alu_count < Q_FULL);
    assign ls_ready  = !rst && (ls_count < Q_FULL);
    assign alu_push  = alu_valid && alu_ready;
    assign ls_push   = ls_valid && ls_ready;

    assign alu_nonempty = (alu_count != '0);
    assign ls_nonempty  = (ls_count != '0);

    wb_fifo #(.DEPTH(Q_DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   ({alu_pos, alu_rd, alu_value, alu_offset}),
        .head  (alu_head),
        .count (alu_count)
    );

    wb_fifo #(.DEPTH(Q_DEPTH), .WIDTH(ENTRY_W)) u_ls_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ls_push),
        .pop   (ls_pop),
        .din   ({ls_pos, ls_rd, ls_value, ADDR_WIDTH'(DEFAULT_PC_STEP)}),
        .head  (ls_head),
        .count (ls_count)
    );

    // Pick the source to drain this cycle from pre-push FIFO occupancy.
    always_comb begin
        grant_valid = alu_nonempty || ls_nonempty;
        grant       = WB_SRC_ALU;
        if (alu_nonempty && ls_nonempty) begin
            if (ALU_PRIORITY == 0) begin
                grant = ~last_grant;
            end else begin
                grant = (starve_cnt == STARVE_MAX) ? WB_SRC_LS : WB_SRC_ALU;
            end
        end else if (ls_nonempty) begin
            grant = WB_SRC_LS;
        end
    end

    assign alu_pop   = grant_valid && (grant == WB_SRC_ALU);
    assign ls_pop    = grant_valid && (grant == WB_SRC_LS);
    assign sel_entry = (grant == WB_SRC_LS) ? ls_head : alu_head;
    assign sel_rd    = sel_entry[RD_LSB +: REG_WIDTH];

    // Register the broadcast and track fairness state; x0 writes broadcast value 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_src     <= 1'b0;
            wb_pos     <= '0;
            wb_rd      <= '0;
            wb_value   <= '0;
            wb_offset  <= '0;
            last_grant <= WB_SRC_LS;
            starve_cnt <= '0;
        end else begin
            if (grant_valid) begin
                wb_valid   <= 1'b1;
                wb_src     <= grant;
                wb_pos     <= sel_entry[POS_LSB +: SB_SIZE_WIDTH];
                wb_rd      <= sel_rd;
                wb_value   <= (sel_rd == '0) ? '0 : sel_entry[VAL_LSB +: DATA_WIDTH];
                wb_offset  <= sel_entry[0 +: ADDR_WIDTH];
                last_grant <= grant;
            end else begin
                wb_valid <= 1'b0;
            end
            if (!ls_nonempty || ls_pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a round-robin instance (rr_*) and an ALU-priority
// instance (p_*). Stimulus pushes expected broadcasts {src,pos,rd,value,offset}
// plus the cycle they must appear in; a monitor pops and compares.
module tb_wb_arbiter;

  localparam int W = 74;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] rr_q[$];
  int           rr_cq[$];
  logic [W-1:0] p_q[$];
  int           p_cq[$];

  // round-robin instance signals
  logic        rr_rst, rr_alu_valid, rr_alu_ready, rr_ls_valid, rr_ls_ready;
  logic [3:0]  rr_alu_pos, rr_ls_pos, rr_wb_pos;
  logic [4:0]  rr_alu_rd, rr_ls_rd, rr_wb_rd;
  logic [31:0] rr_alu_value, rr_alu_offset, rr_ls_value, rr_wb_value, rr_wb_offset;
  logic        rr_wb_valid, rr_wb_src;

  // priority instance signals
  logic        p_rst, p_alu_valid, p_alu_ready, p_ls_valid, p_ls_ready;
  logic [3:0]  p_alu_pos, p_ls_pos, p_wb_pos;
  logic [4:0]  p_alu_rd, p_ls_rd, p_wb_rd;
  logic [31:0] p_alu_value, p_alu_offset, p_ls_value, p_wb_value, p_wb_offset;
  logic        p_wb_valid, p_wb_src;

  wb_arbiter u_rr (
    .clk(clk), .rst(rr_rst),
    .alu_valid(rr_alu_valid), .alu_ready(rr_alu_ready), .alu_pos(rr_alu_pos),
    .alu_rd(rr_alu_rd), .alu_value(rr_alu_value), .alu_offset(rr_alu_offset),
    .ls_valid(rr_ls_valid), .ls_ready(rr_ls_ready), .ls_pos(rr_ls_pos),
    .ls_rd(rr_ls_rd), .ls_value(rr_ls_value),
    .wb_valid(rr_wb_valid), .wb_src(rr_wb_src), .wb_pos(rr_wb_pos),
    .wb_rd(rr_wb_rd), .wb_value(rr_wb_value), .wb_offset(rr_wb_offset)
  );

  wb_arbiter #(.ALU_PRIORITY(1), .STARVE_LIMIT(3)) u_pri (
    .clk(clk), .rst(p_rst),
    .alu_valid(p_alu_valid), .alu_ready(p_alu_ready), .alu_pos(p_alu_pos),
    .alu_rd(p_alu_rd), .alu_value(p_alu_value), .alu_offset(p_alu_offset),
    .ls_valid(p_ls_valid), .ls_ready(p_ls_ready), .ls_pos(p_ls_pos),
    .ls_rd(p_ls_rd), .ls_value(p_ls_value),
    .wb_valid(p_wb_valid), .wb_src(p_wb_src), .wb_pos(p_wb_pos),
    .wb_rd(p_wb_rd), .wb_value(p_wb_value), .wb_offset(p_wb_offset)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] pk(input logic src, input logic [3:0] pos,
                                      input logic [4:0] rd, input logic [31:0] val,
                                      input logic [31:0] off);
    return {src, pos, rd, val, off};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks (round-robin instance)
  task automatic rr_idle();
    rr_alu_valid = 1'b0; rr_alu_pos = '0; rr_alu_rd = '0; rr_alu_value = '0; rr_alu_offset = '0;
    rr_ls_valid = 1'b0; rr_ls_pos = '0; rr_ls_rd = '0; rr_ls_value = '0;
  endtask

  task automatic rr_alu(input logic [3:0] pos, input logic [4:0] rd,
                        input logic [31:0] val, input logic [31:0] off);
    rr_alu_valid = 1'b1; rr_alu_pos = pos; rr_alu_rd = rd; rr_alu_value = val; rr_alu_offset = off;
  endtask

  task automatic rr_ls(input logic [3:0] pos, input logic [4:0] rd, input logic [31:0] val);
    rr_ls_valid = 1'b1; rr_ls_pos = pos; rr_ls_rd = rd; rr_ls_value = val;
  endtask

  task automatic rr_exp(input logic [W-1:0] e, input int c);
    rr_q.push_back(e);
    rr_cq.push_back(c);
  endtask

  task automatic p_idle();
    p_alu_valid = 1'b0; p_alu_pos = '0; p_alu_rd = '0; p_alu_value = '0; p_alu_offset = '0;
    p_ls_valid = 1'b0; p_ls_pos = '0; p_ls_rd = '0; p_ls_value = '0;
  endtask

  // scoreboard monitor: compare every broadcast with the head of its queue
  task automatic mon_loop();
    logic [W-1:0] e;
    int ec;
    forever begin
      @(negedge clk);
      if (rr_wb_valid === 1'b1) begin
        checks++;
        if (rr_q.size() == 0) begin
          errors++;
          $display("FAIL rr_unexpected_wb: got %h @%0d expected none",
                   {rr_wb_src, rr_wb_pos, rr_wb_rd, rr_wb_value, rr_wb_offset}, cyc);
        end else begin
          e = rr_q.pop_front();
          ec = rr_cq.pop_front();
          if ({rr_wb_src, rr_wb_pos, rr_wb_rd, rr_wb_value, rr_wb_offset} !== e || cyc != ec) begin
            errors++;
            $display("FAIL rr_wb: got %h @%0d expected %h @%0d",
                     {rr_wb_src, rr_wb_pos, rr_wb_rd, rr_wb_value, rr_wb_offset}, cyc, e, ec);
          end
        end
      end
      if (p_wb_valid === 1'b1) begin
        checks++;
        if (p_q.size() == 0) begin
          errors++;
          $display("FAIL pri_unexpected_wb: got %h @%0d expected none",
                   {p_wb_src, p_wb_pos, p_wb_rd, p_wb_value, p_wb_offset}, cyc);
        end else begin
          e = p_q.pop_front();
          ec = p_cq.pop_front();
          if ({p_wb_src, p_wb_pos, p_wb_rd, p_wb_value, p_wb_offset} !== e || cyc != ec) begin
            errors++;
            $display("FAIL pri_wb: got %h @%0d expected %h @%0d",
                     {p_wb_src, p_wb_pos, p_wb_rd, p_wb_value, p_wb_offset}, cyc, e, ec);
          end
        end
      end
    end
  endtask

  initial begin
    int c;
    int ai;
    int lj;
    int na;
    int nl;
    fork
      mon_loop();
    join_none

    // reset
    rr_idle(); p_idle();
    rr_rst = 1'b1; p_rst = 1'b1;
    step(); step();
    chk("ready_low_in_reset", {rr_alu_ready, rr_ls_ready}, 2'b00);
    rr_rst = 1'b0; p_rst = 1'b0;
    step();
    chk("reset_wb_outputs",
        {rr_wb_valid, rr_wb_src, rr_wb_pos, rr_wb_rd, rr_wb_value, rr_wb_offset}, '0);
    chk("reset_ready", {rr_alu_ready, rr_ls_ready}, 2'b11);

    // single ALU result
    c = cyc;
    rr_alu(4'd3, 5'd5, 32'h1234, 32'd8);
    rr_exp(pk(1'b0, 4'd3, 5'd5, 32'h1234, 32'd8), c + 2);
    step(); rr_idle();
    repeat (3) step();

    // same-cycle collision right after reset: ALU wins the first tie
    rr_rst = 1'b1; step(); rr_rst = 1'b0;
    c = cyc;
    rr_alu(4'd1, 5'd1, 32'h11, 32'd4);
    rr_ls(4'd2, 5'd2, 32'hAA);
    rr_exp(pk(1'b0, 4'd1, 5'd1, 32'h11, 32'd4), c + 2);
    rr_exp(pk(1'b1, 4'd2, 5'd2, 32'hAA, 32'd4), c + 3);
    step(); rr_idle();
    repeat (3) step();

    // ALU alone, then a collision: round-robin now favours LS
    c = cyc;
    rr_alu(4'd4, 5'd6, 32'h44, 32'd12);
    rr_exp(pk(1'b0, 4'd4, 5'd6, 32'h44, 32'd12), c + 2);
    step(); rr_idle();
    repeat (3) step();
    c = cyc;
    rr_alu(4'd5, 5'd7, 32'h55, 32'd16);
    rr_ls(4'd6, 5'd8, 32'hBB);
    rr_exp(pk(1'b1, 4'd6, 5'd8, 32'hBB, 32'd4), c + 2);
    rr_exp(pk(1'b0, 4'd5, 5'd7, 32'h55, 32'd16), c + 3);
    step(); rr_idle();
    repeat (3) step();

    // rd = 0: still broadcast, value forced to 0
    c = cyc;
    rr_ls(4'd7, 5'd0, 32'hDEAD);
    rr_exp(pk(1'b1, 4'd7, 5'd0, 32'h0, 32'd4), c + 2);
    step(); rr_idle();
    repeat (3) step();

    // reset mid-operation (last grant was LS, so ALU wins the first tie)
    c = cyc;
    rr_alu(4'd8, 5'd9, 32'h80, 32'd4);
    rr_ls(4'd9, 5'd10, 32'h90);
    rr_exp(pk(1'b0, 4'd8, 5'd9, 32'h80, 32'd4), c + 2);
    step();
    rr_alu(4'd10, 5'd11, 32'hA0, 32'd4);
    rr_ls(4'd11, 5'd12, 32'hB0);
    step();
    chk("ls_full_not_ready", {31'd0, rr_ls_ready}, '0);
    rr_idle();
    rr_alu(4'd12, 5'd13, 32'hC0, 32'd4);
    rr_exp(pk(1'b1, 4'd9, 5'd10, 32'h90, 32'd4), c + 3);
    step();
    rr_idle();
    rr_rst = 1'b1;
    step();
    rr_rst = 1'b0;
    #1;
    chk("ready_after_mid_reset", {rr_alu_ready, rr_ls_ready}, 2'b11);
    chk("wb_cleared_after_mid_reset",
        {rr_wb_valid, rr_wb_src, rr_wb_pos, rr_wb_rd, rr_wb_value, rr_wb_offset}, '0);
    repeat (5) step();

    // wrap-around: 10 back-to-back ALU results
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("alu_ready_stream_%0d", i), {31'd0, rr_alu_ready}, 1);
      rr_alu(4'(i), 5'(i + 1), 32'h100 + 32'(i), 32'd4);
      rr_exp(pk(1'b0, 4'(i), 5'(i + 1), 32'h100 + 32'(i), 32'd4), c + 2 + i);
      step();
    end
    rr_idle();
    repeat (4) step();

    // ALU priority with starvation guard: LS every 4th broadcast
    c = cyc;
    na = 0; nl = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k % 4 == 0) begin
        p_q.push_back(pk(1'b1, 4'(nl + 8), 5'(nl + 20), 32'h2000 + 32'(nl), 32'd4));
        nl++;
      end else begin
        p_q.push_back(pk(1'b0, 4'(na), 5'(na + 1), 32'h1000 + 32'(na), 32'h100 + 32'(na * 4)));
        na++;
      end
      p_cq.push_back(c + 1 + k);
    end
    ai = 0; lj = 0;
    for (int m = 0; m <= 16; m++) begin
      p_alu_valid = 1'b1; p_alu_pos = 4'(ai); p_alu_rd = 5'(ai + 1);
      p_alu_value = 32'h1000 + 32'(ai); p_alu_offset = 32'h100 + 32'(ai * 4);
      p_ls_valid = 1'b1; p_ls_pos = 4'(lj + 8); p_ls_rd = 5'(lj + 20);
      p_ls_value = 32'h2000 + 32'(lj);
      if (m == 2) chk("pri_ls_ready_low_after_2", {31'd0, p_ls_ready}, '0);
      if (p_alu_ready) ai++;
      if (p_ls_ready) lj++;
      step();
    end
    p_idle();
    p_rst = 1'b1;
    step();
    p_rst = 1'b0;
    repeat (4) step();

    chk("rr_queue_drained", 80'(rr_q.size()), '0);
    chk("pri_queue_drained", 80'(p_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
